// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef logic [1:0] bubble_t;

    localparam bubble_t BUB_PASS  = 2'b00;
    localparam bubble_t BUB_STALL = 2'b01;
    localparam bubble_t BUB_FLUSH = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for MULT_CYCLES-2 with MULT_CYCLES up to 15.
    localparam int MCNT_W = 4;

    typedef enum logic {
        RUN,
        MULT_WAIT
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline, slave is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic [4:0]       rw_ex;
    logic             RegWr_ex;
    logic             MemtoReg_ex;
    logic             mult_ex;
    logic             taken_mem;

    logic             pc_write;
    logic             ifid_hold;
    logic             idex_hold;
    logic [1:0]       ifid_bubbles;
    logic [1:0]       idex_bubbles;
    logic [1:0]       exmem_bubbles;
    logic [1:0]       memwb_bubbles;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, rw_ex, RegWr_ex, MemtoReg_ex,
               mult_ex, taken_mem,
        input  pc_write, ifid_hold, idex_hold, ifid_bubbles, idex_bubbles,
               exmem_bubbles, memwb_bubbles, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, rw_ex, RegWr_ex, MemtoReg_ex,
               mult_ex, taken_mem,
        output pc_write, ifid_hold, idex_hold, ifid_bubbles, idex_bubbles,
               exmem_bubbles, memwb_bubbles, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    input  logic       use_rs_id_i,
    input  logic       use_rt_id_i,
    input  logic [4:0] rw_ex_i,
    input  logic       RegWr_ex_i,
    input  logic       MemtoReg_ex_i,
    output logic       stall_req_o
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;

    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign load_in_ex  = MemtoReg_ex_i & RegWr_ex_i & (rw_ex_i != REG_ZERO);
    assign rs_match    = use_rs_id_i & (rs_id_i == rw_ex_i);
    assign rt_match    = use_rt_id_i & (rt_id_i == rw_ex_i);
    assign stall_req_o = load_in_ex & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: Mealy control outputs, registered FSM, mult counter and stats.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam bit               MULT_STALLS = (MULT_CYCLES > 1);
    localparam logic [MCNT_W-1:0] MCNT_INIT  =
        MULT_STALLS ? MCNT_W'(MULT_CYCLES - 2) : '0;

    state_t            state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic    pc_write;
    logic    ifid_hold;
    logic    idex_hold;
    bubble_t ifid_bub;
    bubble_t idex_bub;
    bubble_t exmem_bub;
    bubble_t memwb_bub;
    logic    flush_evt;
    logic    stall_req;

    hazard_detect u_hazard_detect (
        .rs_id_i       (bus.rs_id),
        .rt_id_i       (bus.rt_id),
        .use_rs_id_i   (bus.use_rs_id),
        .use_rt_id_i   (bus.use_rt_id),
        .rw_ex_i       (bus.rw_ex),
        .RegWr_ex_i    (bus.RegWr_ex),
        .MemtoReg_ex_i (bus.MemtoReg_ex),
        .stall_req_o   (stall_req)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_write  = 1'b1;
        ifid_hold = 1'b0;
        idex_hold = 1'b0;
        ifid_bub  = BUB_PASS;
        idex_bub  = BUB_PASS;
        exmem_bub = BUB_PASS;
        memwb_bub = BUB_PASS;
        state_d   = state_q;
        mcnt_d    = mcnt_q;
        flush_evt = 1'b0;

        if (reset) begin
            pc_write  = 1'b0;
            ifid_bub  = BUB_FLUSH;
            idex_bub  = BUB_FLUSH;
            exmem_bub = BUB_FLUSH;
            memwb_bub = BUB_FLUSH;
        end else if (bus.taken_mem) begin
            // A redirect kills everything younger than MEM, including a mult in flight.
            ifid_bub  = BUB_FLUSH;
            idex_bub  = BUB_FLUSH;
            exmem_bub = BUB_FLUSH;
            state_d   = RUN;
            mcnt_d    = '0;
            flush_evt = 1'b1;
        end else if (state_q == MULT_WAIT) begin
            if (mcnt_q != '0) begin
                pc_write  = 1'b0;
                ifid_hold = 1'b1;
                idex_hold = 1'b1;
                exmem_bub = BUB_STALL;
                mcnt_d    = mcnt_q - 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (bus.mult_ex && MULT_STALLS) begin
            pc_write  = 1'b0;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
            exmem_bub = BUB_STALL;
            mcnt_d    = MCNT_INIT;
            state_d   = MULT_WAIT;
        end else if (stall_req) begin
            pc_write  = 1'b0;
            ifid_hold = 1'b1;
            idex_bub  = BUB_STALL;
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.ifid_hold     = ifid_hold;
    assign bus.idex_hold     = idex_hold;
    assign bus.ifid_bubbles  = ifid_bub;
    assign bus.idex_bubbles  = idex_bub;
    assign bus.exmem_bubbles = exmem_bub;
    assign bus.memwb_bubbles = memwb_bub;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule
